oled_seq: RTL and testbench

Command sequencer between the Avalon-MM slave port of `spimaster` and the rest of the SSD1331 display path. After reset it waits a power-up delay, then streams the SSD1331 initialisation sequence from an internal ROM, one byte per SPI transfer, polling the master's idle bit between bytes. Once initialisation completes it accepts single bytes, command or pixel data, from one client over a valid/ready handshake and forwards each to `spimaster` with the same pacing. It is the only writer on the `spimaster` bus.

---
 rtl/oled_pkg.sv | 30 +++
 rtl/oled_seq.sv | 135 +++++++++++++
 tb/tb_oled_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 command sequencer: FSM states and the
// power-on initialisation byte stream.
package oled_pkg;

    typedef enum logic [2:0] {
        BOOT,
        ISSUE,
        GUARD_W,
        WAIT,
        IDLE
    } state_t;

    localparam int INIT_LEN = 37;
    localparam int INIT_IW  = $clog2(INIT_LEN + 1);

    localparam logic [8:0] CMD_FLAG = 9'h100;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
        8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
        8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
        8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'hAF
    };

    // Every init byte is a command, so DC is driven low for all of them.
    function automatic logic [8:0] rom_word(input logic [INIT_IW-1:0] idx);
        return CMD_FLAG | {1'b0, INIT_ROM[idx]};
    endfunction

endpackage

// File: rtl/oled_seq.sv
// Sole writer on the spimaster Avalon-MM port: boot delay, SSD1331 init stream,
// then single client bytes, each paced by polling the master's idle bit.
module oled_seq
    import oled_pkg::*;
#(
    parameter int BOOT_CYCLES = 1000,
    parameter int GUARD       = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] spi_writedata,
    output logic        spi_write,
    output logic        spi_read,
    input  logic [31:0] spi_readdata,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_is_cmd,
    output logic        init_done,
    output logic        err
);

    // One shared counter serves BOOT, GUARD_W and WAIT; it clears on every state change.
    localparam int CNT_MAX = (BOOT_CYCLES > GUARD)
                           ? ((BOOT_CYCLES > TIMEOUT) ? BOOT_CYCLES : TIMEOUT)
                           : ((GUARD > TIMEOUT) ? GUARD : TIMEOUT);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]      CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0]      BOOT_LAST = CW'(BOOT_CYCLES - 1);
    localparam logic [CW-1:0]      GRD_LAST  = CW'(GUARD - 1);
    localparam logic [CW-1:0]      TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [INIT_IW-1:0] ROM_LAST  = INIT_IW'(INIT_LEN - 1);

    state_t               r_state, w_state_next;
    logic [CW-1:0]        r_cnt, w_cnt_next;
    logic [INIT_IW-1:0]   r_idx, w_idx_next;
    logic [INIT_IW-1:0]   w_idx_inc;
    logic [8:0]           r_wdata, w_wdata_next;
    logic                 r_init_done, w_init_done_next;
    logic                 r_err, w_err_next;
    logic                 w_idle;
    logic                 w_unused_rd;

    assign w_idle      = spi_readdata[0];
    assign w_unused_rd = ^spi_readdata[31:1];
    assign w_idx_inc   = r_idx + 1'b1;

    assign spi_write     = (r_state == ISSUE);
    assign spi_read      = (r_state == WAIT);
    assign spi_writedata = {23'b0, r_wdata};
    assign cmd_ready     = (r_state == IDLE) && r_init_done;
    assign init_done     = r_init_done;
    assign err           = r_err;

    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_wdata_next     = r_wdata;
        w_init_done_next = r_init_done;
        w_err_next       = r_err;
        w_cnt_next       = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

        case (r_state)
            BOOT: begin
                if (r_cnt >= BOOT_LAST) begin
                    w_state_next = ISSUE;
                    w_idx_next   = '0;
                    w_wdata_next = rom_word('0);
                end
            end
            ISSUE: begin
                w_state_next = (GUARD == 0) ? WAIT : GUARD_W;
            end
            GUARD_W: begin
                if (r_cnt >= GRD_LAST) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // A timeout advances exactly like a seen idle, only flagging err.
                if (w_idle || (r_cnt >= TMO_LAST)) begin
                    if (!w_idle) begin
                        w_err_next = 1'b1;
                    end
                    if (!r_init_done) begin
                        w_idx_next = w_idx_inc;
                        if (r_idx >= ROM_LAST) begin
                            w_init_done_next = 1'b1;
                            w_state_next     = IDLE;
                        end else begin
                            w_wdata_next = rom_word(w_idx_inc);
                            w_state_next = ISSUE;
                        end
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_wdata_next = {cmd_is_cmd, cmd_byte};
                    w_state_next = ISSUE;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase

        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= BOOT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_wdata     <= w_wdata_next;
            r_init_done <= w_init_done_next;
            r_err       <= w_err_next;
        end
    end

endmodule

// File: tb/tb_oled_seq.sv
// Directed and randomized checks of oled_seq against a cycle-level model of
// the spimaster idle bit and a timing model built from the byte-period rules.
module tb_oled_seq;

    localparam int B = 1000;
    localparam int G = 2;
    localparam int T = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] spi_writedata;
    logic        spi_write;
    logic        spi_read;
    logic [31:0] spi_readdata = 32'h1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_byte = 8'h00;
    logic        cmd_is_cmd = 1'b0;
    logic        init_done;
    logic        err;

    oled_seq #(.BOOT_CYCLES(B), .GUARD(G), .TIMEOUT(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_writedata (spi_writedata),
        .spi_write     (spi_write),
        .spi_read      (spi_read),
        .spi_readdata  (spi_readdata),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_byte      (cmd_byte),
        .cmd_is_cmd    (cmd_is_cmd),
        .init_done     (init_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [37] = '{
        8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
        8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
        8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
        8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'hAF
    };

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          rel_cyc = 0;
    int          strobe_cyc[$];
    logic [31:0] strobe_data[$];
    int          strobe_busy[$];
    int          busy_left = 0;
    int          busy_len = 0;
    int          mon_l = 0;
    bit          rand_busy = 1'b0;
    bit          force_busy = 1'b0;
    int          done_cyc = -1;
    int          err_cyc = -1;
    bit          ready_in_init = 1'b0;

    initial forever @(posedge clk) cyc++;

    // Master model: after seeing a strobe it reports busy for L samples.
    // The sequencer then spends W = max(0, L-G-1) busy WAIT cycles.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            busy_left = 0;
        end else if (spi_write) begin
            mon_l = rand_busy ? int'($urandom_range(0, 30)) : busy_len;
            strobe_cyc.push_back(cyc);
            strobe_data.push_back(spi_writedata);
            strobe_busy.push_back(mon_l);
            busy_left = mon_l;
            $display("xfer %0d cyc %0d data %03h busy %0d", strobe_cyc.size() - 1,
                     cyc - rel_cyc, spi_writedata, mon_l);
        end else if (busy_left > 0) begin
            busy_left--;
        end
        spi_readdata = {31'b0, !force_busy && (busy_left == 0)};
        if (init_done && done_cyc < 0) done_cyc = cyc;
        if (err && err_cyc < 0) err_cyc = cyc;
        if (cmd_ready && !init_done) ready_in_init = 1'b1;
    end

    function automatic int exp_gap(input int l);
        return 1 + G + ((l > G + 1) ? l - G - 1 : 0) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        strobe_cyc.delete();
        strobe_data.delete();
        strobe_busy.delete();
        done_cyc = -1;
        err_cyc = -1;
        ready_in_init = 1'b0;
        @(negedge clk);
        chk("rst_write", 32'(spi_write), 32'd0);
        chk("rst_read", 32'(spi_read), 32'd0);
        chk("rst_wdata", spi_writedata, 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!init_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(init_done), 32'd1);
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (strobe_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(strobe_cyc.size() >= n), 32'd1);
    endtask

    task automatic check_init(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, 32'(strobe_cyc.size()), 32'd37);
        if (strobe_cyc.size() >= 37) begin
            chk({tag, "_first_cyc"}, 32'(strobe_cyc[0] - rel_cyc), 32'(B));
            for (int i = 0; i < 37; i++) begin
                chk($sformatf("%s_rom%0d", tag, i), strobe_data[i], {23'b0, 1'b1, rom[i]});
                if (i > 0)
                    chk($sformatf("%s_gap%0d", tag, i), 32'(strobe_cyc[i] - strobe_cyc[i-1]),
                        32'(exp_gap(strobe_busy[i-1])));
            end
            chk({tag, "_done_cyc"}, 32'(done_cyc - strobe_cyc[36]), 32'(exp_gap(strobe_busy[36])));
        end
        chk({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic c, input string tag);
        int k = 0;
        int h;
        int n0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_byte = b;
        cmd_is_cmd = c;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        h = cyc + 1;
        n0 = strobe_cyc.size();
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({tag, "_strobe"}, 32'(spi_write), 32'd1);
        chk({tag, "_wdata"}, spi_writedata, {23'b0, c, b});
        chk({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_count"}, 32'(strobe_cyc.size()), 32'(n0 + 1));
        if (strobe_cyc.size() > n0) begin
            chk({tag, "_strobe_cyc"}, 32'(strobe_cyc[n0]), 32'(h));
            chk({tag, "_return_idle"}, 32'(cyc - h), 32'(exp_gap(strobe_busy[n0])));
        end
    endtask

    initial begin
        // Idle always: minimum byte period, then one pixel byte from the client.
        busy_len = 0;
        do_reset();
        wait_done(3000, "idle_done");
        check_init("idle");
        send(8'h5A, 1'b0, "client5a");

        // Master busy long enough for 20 WAIT cycles per byte.
        busy_len = G + 21;
        do_reset();
        wait_done(4000, "busy20_done");
        check_init("busy20");
        if (strobe_cyc.size() >= 2)
            chk("busy20_period", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(G + 22));

        // Random busy lengths for init and a burst of random client bytes.
        rand_busy = 1'b1;
        do_reset();
        wait_done(4000, "rand_done");
        check_init("rand");
        for (int i = 0; i < 6; i++)
            send(8'($urandom), 1'($urandom), $sformatf("client_r%0d", i));
        rand_busy = 1'b0;

        // Client valid held throughout boot and init.
        busy_len = 0;
        do_reset();
        cmd_valid = 1'b1;
        cmd_byte = 8'hC3;
        cmd_is_cmd = 1'b1;
        wait_done(3000, "early_done");
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("early_ready_in_init", 32'(ready_in_init), 32'd0);
        chk("early_count", 32'(strobe_cyc.size()), 32'd38);
        if (strobe_cyc.size() >= 38) begin
            chk("early_data", strobe_data[37], 32'h1C3);
            chk("early_cyc", 32'(strobe_cyc[37] - done_cyc), 32'd1);
        end

        // Master never idle: timeout flags err and moves to the next ROM byte.
        force_busy = 1'b1;
        do_reset();
        wait_strobes(2, B + T + 100, "tmo_strobes");
        if (strobe_cyc.size() >= 2) begin
            chk("tmo_first", strobe_data[0], 32'h1AE);
            chk("tmo_second", strobe_data[1], 32'h1A0);
            chk("tmo_period", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'(1 + G + T));
            chk("tmo_err_cyc", 32'(err_cyc), 32'(strobe_cyc[1]));
        end
        force_busy = 1'b0;

        // Reset while waiting on ROM entry 10.
        busy_len = 10;
        do_reset();
        begin
            int k = 0;
            while (!(spi_read && strobe_cyc.size() == 11) && k < 3000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("mid_in_wait", 32'(spi_read), 32'd1);
        chk("mid_entry10", (strobe_data.size() == 11) ? strobe_data[10] : 32'hX, {23'b0, 1'b1, rom[10]});
        do_reset();
        wait_strobes(2, B + 100, "mid_restart");
        if (strobe_cyc.size() >= 2) begin
            chk("mid_first_cyc", 32'(strobe_cyc[0] - rel_cyc), 32'(B));
            chk("mid_first", strobe_data[0], 32'h1AE);
            chk("mid_second", strobe_data[1], 32'h1A0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
